// File: rtl/cipher_cfg_sequencer.sv
// Byte-wide host loader for the stream cipher's serial config chain; gates keystream enables during a load.
// Optional readback of the outgoing chain bits is compiled in with `define CFG_READBACK_EN.
module cipher_cfg_sequencer #(
    parameter int CFG_BITS = 259,
    parameter int NBYTES   = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       tx_req,
    input  logic       rx_req,
    output logic       cfg_en,
    output logic       cfg_i,
    input  logic       cfg_o,
    output logic       tx_en,
    output logic       rx_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       rd_valid,
    output logic [7:0] rd_data
);
    localparam int CNT_W = $clog2(CFG_BITS + 1);
    localparam int BC_W  = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       sh_q, sh_d;
    logic [3:0]       sh_cnt_q, sh_cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic             err_q, err_d;
    logic             tx_en_q, tx_en_d;
    logic             rx_en_q, rx_en_d;
    logic             accept, nb_vld, load_start, last_bit;
    logic [7:0]       nb;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        sh_cnt_d   = sh_cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        err_d      = err_q;
        tx_en_d    = 1'b0;
        rx_en_d    = 1'b0;
        cfg_en     = 1'b0;
        cfg_i      = 1'b0;
        wr_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        load_start = 1'b0;
        last_bit   = 1'b0;
        nb_vld     = 1'b0;
        nb         = hold_q;

        case (state_q)
            S_IDLE: begin
                if (!abort && start) load_start = 1'b1;
            end
            S_LOAD: begin
                busy       = 1'b1;
                wr_ready   = !hold_vld_q && (byte_cnt_q < BC_W'(NBYTES));
                accept     = wr_valid && wr_ready;
                if (accept) byte_cnt_d = byte_cnt_q + 1'b1;
                // Next byte comes from the holding reg, or straight off the port when it is empty.
                nb_vld     = hold_vld_q || accept;
                nb         = hold_vld_q ? hold_q : wr_data;
                if (sh_cnt_q != 4'd0) begin
                    cfg_en = 1'b1;
                    cfg_i  = sh_q[0];
                    if (sh_cnt_q == 4'd1 && nb_vld) begin
                        sh_d       = nb;
                        sh_cnt_d   = 4'd8;
                        hold_vld_d = 1'b0;
                    end else begin
                        sh_d     = {1'b0, sh_q[7:1]};
                        sh_cnt_d = sh_cnt_q - 4'd1;
                        if (accept) begin
                            hold_d     = wr_data;
                            hold_vld_d = 1'b1;
                        end
                    end
                end else if (nb_vld) begin
                    cfg_en     = 1'b1;
                    cfg_i      = nb[0];
                    sh_d       = {1'b0, nb[7:1]};
                    sh_cnt_d   = 4'd7;
                    hold_vld_d = 1'b0;
                end
                if (cfg_en) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(CFG_BITS - 1)) begin
                        last_bit   = 1'b1;
                        state_d    = S_DRAIN;
                        sh_cnt_d   = 4'd0;
                        hold_vld_d = 1'b0;
                    end
                end
                if (abort) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    sh_cnt_d   = 4'd0;
                    hold_vld_d = 1'b0;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    load_start = 1'b1;
                end else begin
                    tx_en_d = tx_req;
                    rx_en_d = rx_req;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_start) begin
            state_d    = S_LOAD;
            err_d      = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            sh_cnt_d   = 4'd0;
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sh_cnt_q   <= 4'd0;
            hold_vld_q <= 1'b0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            err_q      <= 1'b0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            hold_vld_q <= hold_vld_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
        end
    end

    // Byte payload registers are qualified by sh_cnt_q / hold_vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        sh_q   <= sh_d;
        hold_q <= hold_d;
    end

    assign tx_en = tx_en_q;
    assign rx_en = rx_en_q;
    assign err   = err_q;

`ifdef CFG_READBACK_EN
    localparam int REM = CFG_BITS % 8;

    logic [7:0] cap_q, cap_d;
    logic [2:0] cap_cnt_q, cap_cnt_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;

    always_comb begin
        cap_d      = cap_q;
        cap_cnt_d  = cap_cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (load_start || abort) begin
            cap_d     = 8'd0;
            cap_cnt_d = 3'd0;
        end else if (cfg_en) begin
            cap_d     = {cfg_o, cap_q[7:1]};
            cap_cnt_d = cap_cnt_q + 3'd1;
            if (cap_cnt_q == 3'd7) begin
                rd_valid_d = 1'b1;
                rd_data_d  = cap_d;
            end else if (last_bit) begin
                // Partial final byte: right-justify the captured bits, zeros above.
                rd_valid_d = 1'b1;
                rd_data_d  = cap_d >> (8 - REM);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q      <= 8'd0;
            cap_cnt_q  <= 3'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            cap_q      <= cap_d;
            cap_cnt_q  <= cap_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`else
    logic unused_cfg_o;
    assign unused_cfg_o = cfg_o;
    assign rd_valid     = 1'b0;
    assign rd_data      = 8'd0;
`endif

endmodule

// File: tb/tb_cipher_cfg_sequencer.sv
// Scoreboard bench for cipher_cfg_sequencer: random images, a queue-based cipher chain model,
// and a negedge monitor that pops expected bits / readback bytes as the DUT presents them.
module tb_cipher_cfg_sequencer;
    localparam int CFG_BITS = 259;
    localparam int NBYTES   = 33;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, wr_valid = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       tx_req = 1'b0, rx_req = 1'b0;
    logic       cfg_o = 1'b0;
    logic       wr_ready, cfg_en, cfg_i, tx_en, rx_en, busy, done, err, rd_valid;
    logic [7:0] rd_data;

    cipher_cfg_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .tx_req(tx_req), .rx_req(rx_req),
        .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o),
        .tx_en(tx_en), .rx_en(rx_en), .busy(busy), .done(done), .err(err),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Cipher chain model: 259-bit FIFO of config bits, oldest bit presented on cfg_o.
    bit chain[$];
    always @(posedge clk) begin
        if (rst) begin
            chain.delete();
            for (int i = 0; i < CFG_BITS; i++) chain.push_back(1'b0);
            cfg_o <= 1'b0;
        end else if (cfg_en === 1'b1) begin
            void'(chain.pop_front());
            chain.push_back(cfg_i);
            cfg_o <= chain[0];
        end
    end

    // Scoreboard queues filled by the driver, drained by the monitor.
    bit         exp_bits[$];
    logic [7:0] exp_rd[$];
    int         bits_seen = 0;
    int         stall_cnt = 0;
    int         done_cnt  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_en) begin
                bits_seen++;
                chk("bit_pending", 32'(exp_bits.size() != 0), 32'd1);
                if (exp_bits.size() != 0) chk("cfg_i", 32'(cfg_i), 32'(exp_bits.pop_front()));
                chk("en_while_cfg", 32'({tx_en, rx_en}), 32'd0);
`ifndef CFG_READBACK_EN
                chk("rd_off", 32'({rd_valid, rd_data}), 32'd0);
`endif
            end else if (busy && !done) begin
                stall_cnt++;
                chk("en_while_stall", 32'({tx_en, rx_en}), 32'd0);
            end
            if (done) done_cnt++;
`ifdef CFG_READBACK_EN
            if (rd_valid) begin
                chk("rd_pending", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
`endif
        end
    end

    task automatic do_load(input bit pat55, input int gap_byte, input int abort_bits);
        logic [7:0] img[NBYTES];
        logic [7:0] v;
        int k, guard, g, nb, s_cyc, d_cyc, d0;
        bit acc, rdy34, first;

        for (int i = 0; i < NBYTES; i++) img[i] = pat55 ? 8'h55 : 8'($urandom);
        exp_bits.delete();
        for (int b = 0; b < CFG_BITS; b++) exp_bits.push_back(img[b / 8][b % 8]);
        exp_rd.delete();
        for (int j = 0; j < NBYTES; j++) begin
            v = 8'd0;
            for (int b = 0; b < 8; b++) if (8 * j + b < CFG_BITS) v[b] = chain[8 * j + b];
            exp_rd.push_back(v);
        end

        bits_seen = 0;
        stall_cnt = 0;
        d0        = done_cnt;
        wr_data   = img[0];
        wr_valid  = 1'b1;
        start     = 1'b1;
        s_cyc     = cyc;
        @(negedge clk);
        chk("ready_before_load", 32'(wr_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;

        k = 0; nb = 0; guard = 0; first = 1'b1;
        while (k < NBYTES && guard < 1000) begin
            @(negedge clk);
            if (first) begin
                chk("cfg_en_first", 32'(cfg_en), 32'd1);
                chk("tx_off_first", 32'(tx_en), 32'd0);
                chk("err_cleared", 32'(err), 32'd0);
                first = 1'b0;
            end
            acc = wr_valid && wr_ready;
            if (cfg_en) nb++;
            if (abort_bits >= 0 && nb >= abort_bits) break;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (acc) begin
                k++;
                if (k == gap_byte + 1) begin
                    wr_valid = 1'b0;
                    g = 0;
                    while (g < 100) begin
                        @(negedge clk);
                        if (!cfg_en) break;
                        g++;
                    end
                    chk("stall_reached", 32'(g < 100), 32'd1);
                    repeat (10) @(posedge clk);
                    #1;
                end
                wr_data  = (k < NBYTES) ? img[k] : 8'hA5;
                wr_valid = 1'b1;
                start    = (k == 10);
            end
        end
        chk("feed_in_time", 32'(guard < 1000), 32'd1);

        if (abort_bits >= 0) begin
            @(posedge clk); #1;
            abort    = 1'b1;
            wr_valid = 1'b0;
            @(posedge clk); #1;
            abort = 1'b0;
            exp_bits.delete();
            exp_rd.delete();
            @(negedge clk);
            chk("abort_idle", 32'(busy), 32'd0);
            chk("abort_err", 32'(err), 32'd1);
            chk("abort_cfg_en", 32'(cfg_en), 32'd0);
            repeat (300) @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done_cnt), 32'(d0));
            chk("abort_tx_idle", 32'(tx_en), 32'd0);
            chk("abort_err_sticky", 32'(err), 32'd1);
        end else begin
            chk("all_bytes_taken", 32'(k), 32'(NBYTES));
            rdy34 = 1'b0; d_cyc = -1; guard = 0;
            while (guard < 400) begin
                @(negedge clk);
                if (done) begin
                    d_cyc = cyc;
                    break;
                end
                if (wr_ready) rdy34 = 1'b1;
                guard++;
            end
            chk("byte34_refused", 32'(rdy34), 32'd0);
            chk("done_latency", 32'(d_cyc - s_cyc), 32'(260 + ((gap_byte >= 0) ? 10 : 0)));
            @(posedge clk); #1;
            wr_valid = 1'b0;
            @(negedge clk);
            chk("tx_first_run", 32'(tx_en), 32'd0);
            chk("busy_run", 32'(busy), 32'd0);
            chk("bits_per_load", 32'(bits_seen), 32'(CFG_BITS));
            chk("stall_cycles", 32'(stall_cnt), 32'((gap_byte >= 0) ? 10 : 0));
            chk("bits_drained", 32'(exp_bits.size()), 32'd0);
`ifdef CFG_READBACK_EN
            chk("rd_drained", 32'(exp_rd.size()), 32'd0);
`endif
            @(negedge clk);
            chk("tx_en_run", 32'(tx_en), 32'(tx_req));
            chk("rx_en_run", 32'(rx_en), 32'(rx_req));
            chk("done_once", 32'(done_cnt), 32'(d0 + 1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({cfg_en, cfg_i, tx_en, rx_en, busy, done, err, wr_ready, rd_valid}), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        tx_req = 1'b1; rx_req = 1'b0;
        do_load(1'b1, -1, -1);

        do_load(1'b0, 4, -1);

        tx_req = 1'b1; rx_req = 1'b1;
        do_load(1'b0, -1, 100);

        tx_req = 1'($urandom); rx_req = 1'($urandom);
        do_load(1'b0, -1, -1);

        tx_req = 1'b0; rx_req = 1'b1;
        do_load(1'b0, -1, -1);

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("run_abort_idle", 32'(busy), 32'd0);
        chk("run_abort_err", 32'(err), 32'd0);
        chk("run_abort_rx_off", 32'(rx_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_bad %0d", n_bad);
        $fatal(1, "watchdog");
    end

endmodule
